// File: rtl/pled_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pled_sequencer
// Description : Three-channel power-LED PWM driver with a command-driven
//               colour fade. A prescaler produces a PWM tick every
//               COUNT_MAX+1 clocks; an 8-bit PWM counter advances on each
//               tick. Duties step toward the commanded target by STEP once
//               per PWM period, and only at period end.
//               Optional build macro PLED_GAMMA_EN applies a square-law
//               gamma curve to the duties before the PWM compare.
// Revision    : 1.0 - initial release
// ============================================================================
module pled_sequencer #(
    parameter int COUNT_MAX = 2700,
    parameter int STEP      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw,
    input  logic        cmd_valid,
    input  logic [23:0] cmd_rgb,
    output logic        cmd_ready,
    output logic        busy,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int            PW           = (COUNT_MAX < 1) ? 1 : $clog2(COUNT_MAX + 1);
    localparam logic [PW-1:0] c_presc_max  = PW'(COUNT_MAX);
    localparam logic [7:0]    c_step       = 8'(STEP);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [7:0]    pwm_cnt_q;
    logic [7:0]    duty_r_q, duty_g_q, duty_b_q;
    logic [7:0]    tgt_r_q, tgt_g_q, tgt_b_q;
    logic          red_q, green_q, blue_q;

    logic          w_tick;
    logic          w_period_end;
    logic          w_at_target;
    logic          w_accept;
    logic [7:0]    w_eff_r, w_eff_g, w_eff_b;

    // Move one duty toward its target by at most c_step; the clamp to the
    // target prevents both overshoot and 8-bit wrap.
    function automatic logic [7:0] f_step_toward(input logic [7:0] cur,
                                                 input logic [7:0] tgt);
        logic [7:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            return (diff > c_step) ? (cur + c_step) : tgt;
        end else begin
            diff = cur - tgt;
            return (diff > c_step) ? (cur - c_step) : tgt;
        end
    endfunction

    // Duty value actually used in the PWM compare.
    function automatic logic [7:0] f_eff(input logic [7:0] d);
`ifdef PLED_GAMMA_EN
        logic [15:0] sq;
        sq = {8'd0, d} * {8'd0, d};
        return sq[15:8];
`else
        return d;
`endif
    endfunction

    assign w_tick       = !sw && (presc_q == c_presc_max);
    assign w_period_end = w_tick && (pwm_cnt_q == 8'hFF);
    assign w_at_target  = (duty_r_q == tgt_r_q) && (duty_g_q == tgt_g_q) &&
                          (duty_b_q == tgt_b_q);
    assign cmd_ready    = rst_n && (state_q == IDLE);
    assign busy         = (state_q == FADE);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_eff_r      = f_eff(duty_r_q);
    assign w_eff_g      = f_eff(duty_g_q);
    assign w_eff_b      = f_eff(duty_b_q);
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;

    // Next-state logic: accept a command in IDLE, leave FADE once all duties match.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept)    state_d = FADE;
            FADE:    if (w_at_target) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // PWM timebase: prescaler and PWM counter, both frozen while paused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= 8'd0;
        end else begin
            if (!sw) presc_q <= (presc_q == c_presc_max) ? '0 : presc_q + PW'(1);
            if (w_tick) pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end

    // Target capture on an accepted command; duties step only at period end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt_r_q  <= 8'd0;
            tgt_g_q  <= 8'd0;
            tgt_b_q  <= 8'd0;
            duty_r_q <= 8'd0;
            duty_g_q <= 8'd0;
            duty_b_q <= 8'd0;
        end else begin
            if (w_accept) begin
                tgt_r_q <= cmd_rgb[23:16];
                tgt_g_q <= cmd_rgb[15:8];
                tgt_b_q <= cmd_rgb[7:0];
            end
            if ((state_q == FADE) && w_period_end) begin
                duty_r_q <= f_step_toward(duty_r_q, tgt_r_q);
                duty_g_q <= f_step_toward(duty_g_q, tgt_g_q);
                duty_b_q <= f_step_toward(duty_b_q, tgt_b_q);
            end
        end
    end

    // Registered PWM compare; outputs hold their value while paused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red_q   <= 1'b0;
            green_q <= 1'b0;
            blue_q  <= 1'b0;
        end else if (!sw) begin
            red_q   <= (pwm_cnt_q < w_eff_r);
            green_q <= (pwm_cnt_q < w_eff_g);
            blue_q  <= (pwm_cnt_q < w_eff_b);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pled_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pled_sequencer
// Description : Self-checking bench for pled_sequencer. Two instances run
//               side by side: a fast one (COUNT_MAX=3, STEP=255) and a slow
//               one (COUNT_MAX=1, STEP=1). A behavioural model tracks both
//               and every cycle is compared; directed sequences and a table
//               of colour vectors check the multi-cycle behaviour.
//               Honours PLED_GAMMA_EN for the expected duty curve.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pled_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sw;
    logic [1:0]  vld;
    logic [23:0] rgb [2];

    logic f_rdy, f_bsy, f_r, f_g, f_b;
    logic s_rdy, s_bsy, s_r, s_g, s_b;

    pled_sequencer #(.COUNT_MAX(3), .STEP(255)) u_fast (
        .clk(clk), .rst_n(rst_n), .sw(sw), .cmd_valid(vld[0]), .cmd_rgb(rgb[0]),
        .cmd_ready(f_rdy), .busy(f_bsy), .red(f_r), .green(f_g), .blue(f_b)
    );

    pled_sequencer #(.COUNT_MAX(1), .STEP(1)) u_slow (
        .clk(clk), .rst_n(rst_n), .sw(sw), .cmd_valid(vld[1]), .cmd_rgb(rgb[1]),
        .cmd_ready(s_rdy), .busy(s_bsy), .red(s_r), .green(s_g), .blue(s_b)
    );

    // ---------------- behavioural reference model ----------------
    int cm  [2] = '{3, 1};
    int stp [2] = '{255, 1};
    int m_presc [2];
    int m_pwm   [2];
    int m_duty  [2][3];
    int m_tgt   [2][3];
    int m_out   [2][3];
    int pe_cnt  [2];
    bit m_fade  [2];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int eff(int d);
`ifdef PLED_GAMMA_EN
        return (d * d) / 256;
`else
        return d;
`endif
    endfunction

    function automatic bit at_tgt(int k);
        return m_duty[k][0] == m_tgt[k][0] && m_duty[k][1] == m_tgt[k][1] &&
               m_duty[k][2] == m_tgt[k][2];
    endfunction

    task automatic model_edge();
        bit tick, pend;
        int d;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_presc[k] = 0; m_pwm[k] = 0; m_fade[k] = 0;
                for (int c = 0; c < 3; c++) begin
                    m_duty[k][c] = 0; m_tgt[k][c] = 0; m_out[k][c] = 0;
                end
            end else begin
                tick = !sw && (m_presc[k] == cm[k]);
                pend = tick && (m_pwm[k] == 255);
                if (!sw)
                    for (int c = 0; c < 3; c++)
                        m_out[k][c] = (m_pwm[k] < eff(m_duty[k][c])) ? 1 : 0;
                if (!m_fade[k]) begin
                    if (vld[k]) begin
                        m_tgt[k][0] = int'(rgb[k][23:16]);
                        m_tgt[k][1] = int'(rgb[k][15:8]);
                        m_tgt[k][2] = int'(rgb[k][7:0]);
                        m_fade[k]   = 1;
                    end
                end else if (at_tgt(k)) begin
                    m_fade[k] = 0;
                end else if (pend) begin
                    for (int c = 0; c < 3; c++) begin
                        d = m_tgt[k][c] - m_duty[k][c];
                        if (d > stp[k])  d = stp[k];
                        if (d < -stp[k]) d = -stp[k];
                        m_duty[k][c] = m_duty[k][c] + d;
                    end
                end
                if (!sw)  m_presc[k] = (m_presc[k] == cm[k]) ? 0 : m_presc[k] + 1;
                if (tick) m_pwm[k] = (m_pwm[k] + 1) % 256;
                if (pend) pe_cnt[k]++;
            end
        end
    endtask

    function automatic logic [31:0] exp_io(int k);
        return {27'd0, (!m_fade[k] && rst_n), m_fade[k], m_out[k][0] != 0,
                m_out[k][1] != 0, m_out[k][2] != 0};
    endfunction

    function automatic logic [31:0] exp_st(int k);
        return {8'(m_pwm[k]), 8'(m_duty[k][0]), 8'(m_duty[k][1]), 8'(m_duty[k][2])};
    endfunction

    function automatic logic [31:0] dut_io(int k);
        if (k == 0) return {27'd0, f_rdy, f_bsy, f_r, f_g, f_b};
        return {27'd0, s_rdy, s_bsy, s_r, s_g, s_b};
    endfunction

    function automatic logic [31:0] dut_st(int k);
        if (k == 0) return {u_fast.pwm_cnt_q, u_fast.duty_r_q, u_fast.duty_g_q, u_fast.duty_b_q};
        return {u_slow.pwm_cnt_q, u_slow.duty_r_q, u_slow.duty_g_q, u_slow.duty_b_q};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model alongside the DUTs and compare everything.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("fast_io", dut_io(0), exp_io(0));
        check("fast_state", dut_st(0), exp_st(0));
        check("slow_io", dut_io(1), exp_io(1));
        check("slow_state", dut_st(1), exp_st(1));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_idle(int k, int max, string nm);
        int n = 0;
        while (((k == 0) ? f_bsy : s_bsy) && n < max) begin
            cycle();
            n++;
        end
        check(nm, {31'd0, (k == 0) ? f_bsy : s_bsy}, 32'd0);
    endtask

    task automatic send(int k, logic [23:0] c);
        vld[k] = 1'b1;
        rgb[k] = c;
        cycle();
        vld[k] = 1'b0;
    endtask

    // ---------------- colour table for the fast instance ----------------
    typedef struct packed {
        logic [23:0] rgb;
        logic [8:0]  lr, lg, lb;   // high ticks per period, linear curve
        logic [8:0]  gr, gg, gb;   // high ticks per period, gamma curve
    } vec_t;

    vec_t tbl [4];

    function automatic int pick(logic [8:0] lin, logic [8:0] gam);
`ifdef PLED_GAMMA_EN
        return int'(gam);
`else
        return int'(lin);
`endif
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe0, hr, hg, hb;

        tbl[0] = '{24'h8000FF, 9'd128, 9'd0,   9'd255, 9'd64, 9'd0,   9'd254};
        tbl[1] = '{24'h01FE10, 9'd1,   9'd254, 9'd16,  9'd0,  9'd252, 9'd1};
        tbl[2] = '{24'h404040, 9'd64,  9'd64,  9'd64,  9'd16, 9'd16,  9'd16};
        tbl[3] = '{24'h000000, 9'd0,   9'd0,   9'd0,   9'd0,  9'd0,   9'd0};

        rst_n = 1'b0; sw = 1'b0; vld = 2'b00; rgb[0] = '0; rgb[1] = '0;

        // Reset held for two clocks, then released.
        run(2);
        check("rst_ready_low", {30'd0, f_rdy, s_rdy}, 32'd0);
        check("rst_busy_outs", {24'd0, f_bsy, f_r, f_g, f_b, s_bsy, s_r, s_g, s_b}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_on_release", {30'd0, f_rdy, s_rdy}, 32'd3);

        // Table: immediate set on the fast instance, then one full period measured.
        for (int i = 0; i < 4; i++) begin
            pe0 = pe_cnt[0];
            send(0, tbl[i].rgb);
            check("fast_busy_after_accept", {31'd0, f_bsy}, 32'd1);
            wait_idle(0, 3000, "fast_fade_timeout");
            check("fast_one_period", pe_cnt[0] - pe0, 32'd1);
            hr = 0; hg = 0; hb = 0;
            for (int j = 0; j < 1024; j++) begin
                cycle();
                hr += int'(f_r); hg += int'(f_g); hb += int'(f_b);
            end
            check("tbl_red_high",   hr, pick(tbl[i].lr, tbl[i].gr) * 4);
            check("tbl_green_high", hg, pick(tbl[i].lg, tbl[i].gg) * 4);
            check("tbl_blue_high",  hb, pick(tbl[i].lb, tbl[i].gb) * 4);
        end

        // Slow fade to green 4; a command offered while busy must be ignored.
        pe0 = pe_cnt[1];
        send(1, 24'h000400);
        run(600);
        check("slow_busy_midfade", {31'd0, s_bsy}, 32'd1);
        vld[1] = 1'b1; rgb[1] = 24'hFFFFFF;
        run(20);
        vld[1] = 1'b0;
        wait_idle(1, 5000, "slow_fade_timeout");
        check("slow_green_duty", {24'd0, u_slow.duty_g_q}, 32'd4);
        check("slow_four_periods", pe_cnt[1] - pe0, 32'd4);
        run(1100);
        check("slow_cmd_ignored", {8'd0, u_slow.duty_r_q, u_slow.duty_g_q, u_slow.duty_b_q},
              32'h000400);

        // Pause mid-fade for 100 clocks: counter, duties and outputs frozen.
        send(1, 24'h050505);
        run(700);
        begin
            logic [31:0] sp, so;
            sp = exp_st(1);
            so = exp_io(1) & 32'h7;
            sw = 1'b1;
            run(100);
            check("pause_state", dut_st(1), sp);
            check("pause_outs", {29'd0, s_r, s_g, s_b}, so);
            sw = 1'b0;
            run(8);
            check("resume_pwm_moved", {31'd0, u_slow.pwm_cnt_q != sp[31:24]}, 32'd1);
        end
        wait_idle(1, 5000, "pause_fade_timeout");

        // Reset in the middle of a fade, then a fresh command.
        send(1, 24'h000000);
        run(300);
        check("rstmid_busy_before", {31'd0, s_bsy}, 32'd1);
        rst_n = 1'b0;
        cycle();
        check("rstmid_state", dut_st(1), 32'd0);
        check("rstmid_io", {27'd0, s_rdy, s_bsy, s_r, s_g, s_b}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rstmid_ready", {31'd0, s_rdy}, 32'd1);
        send(1, 24'h010203);
        check("rstmid_new_cmd_busy", {31'd0, s_bsy}, 32'd1);
        wait_idle(1, 5000, "rstmid_fade_timeout");
        check("rstmid_new_duties", {8'd0, u_slow.duty_r_q, u_slow.duty_g_q, u_slow.duty_b_q},
              32'h010203);

        // Randomised traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            rst_n  = ($urandom_range(0, 2999) != 0);
            if ($urandom_range(0, 499) == 0) sw = ~sw;
            vld[0] = ($urandom_range(0, 199) == 0);
            rgb[0] = 24'($urandom);
            vld[1] = ($urandom_range(0, 99) == 0);
            rgb[1] = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                      8'($urandom_range(0, 3))};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
